// File: rtl/insn_loader_pkg.sv
// Shared definitions for the instruction loader: default sizes, stream header width and FSM states.
package insn_loader_pkg;

   localparam int unsigned DEF_LEN_INSN      = 32;
   localparam int unsigned DEF_MEM_INSN_ADDR = 10;
   localparam int unsigned LEN_BYTE          = 8;
   localparam int unsigned LEN_COUNT         = 2 * LEN_BYTE;

   typedef enum logic [2:0] {
      LDR_HDR_LO = 3'd0,
      LDR_HDR_HI = 3'd1,
      LDR_DATA   = 3'd2,
      LDR_CSUM   = 3'd3,
      LDR_DONE   = 3'd4,
      LDR_ERR    = 3'd5
   } ldr_state_e;

endpackage

// File: rtl/insn_loader_asm.sv
// Byte-to-word assembler: shifts stream bytes in little-endian order and flags the last byte of each word.
module insn_loader_asm
   import insn_loader_pkg::*;
#(
   parameter int unsigned LEN_INSN = DEF_LEN_INSN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic [LEN_BYTE-1:0] byte_i,
   output logic [LEN_INSN-1:0] word_c,
   output logic                word_ready_c
);

   localparam int unsigned BYTES = LEN_INSN / LEN_BYTE;
   localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [LEN_INSN-1:0] shift_q, shift_d;

   // New byte enters at the top, so after BYTES bytes the first one sits in bits [7:0].
   always_comb begin
      word_c       = LEN_INSN'({byte_i, shift_q} >> LEN_BYTE);
      word_ready_c = valid_i && (cnt_q == CW'(BYTES - 1));
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      if (valid_i) begin
         shift_d = word_c;
         cnt_d   = word_ready_c ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/insn_loader.sv
// Instruction-memory loader: parses a counted byte stream, writes LE words from address 0 and holds
// the core in reset until done. Defining INSN_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module insn_loader
   import insn_loader_pkg::*;
#(
   parameter int unsigned LEN_INSN      = DEF_LEN_INSN,
   parameter int unsigned MEM_INSN_ADDR = DEF_MEM_INSN_ADDR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic [LEN_BYTE-1:0]      byte_i,
   output logic                     stall_o,
   input  logic                     mem_stall_i,
   output logic                     we_o,
   output logic [MEM_INSN_ADDR-1:0] waddr_o,
   output logic [LEN_INSN-1:0]      wdata_o,
   output logic                     core_rst_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam int unsigned IDX_W     = MEM_INSN_ADDR + 1;
   localparam int unsigned MAX_WORDS = 32'(1) << MEM_INSN_ADDR;

   ldr_state_e               state_q, state_d;
   logic [LEN_BYTE-1:0]      cnt_lo_q, cnt_lo_d;
   logic [IDX_W-1:0]         n_q, n_d;
   logic [IDX_W-1:0]         widx_q, widx_d;
   logic                     we_q, we_d;
   logic [MEM_INSN_ADDR-1:0] waddr_q, waddr_d;
   logic [LEN_INSN-1:0]      wdata_q, wdata_d;
   logic                     core_rst_q, core_rst_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
`ifdef INSN_LOADER_CHECKSUM_EN
   logic [LEN_BYTE-1:0]      sum_q, sum_d;
`endif

   logic                     wr_busy_c;
   logic                     accept_c;
   logic                     all_words_c;
   logic                     asm_valid_c;
   logic                     word_ready_c;
   logic [LEN_INSN-1:0]      word_c;
   logic [LEN_COUNT-1:0]     n16_c;

   // A write held by the memory blocks the stream, so at most one word is ever pending.
   assign wr_busy_c   = we_q && mem_stall_i;
   assign stall_o     = (state_q == LDR_DONE) || (state_q == LDR_ERR) || wr_busy_c;
   assign accept_c    = valid_i && !stall_o;
   assign all_words_c = (widx_q == n_q);
   assign asm_valid_c = accept_c && (state_q == LDR_DATA) && !all_words_c;

   insn_loader_asm #(.LEN_INSN(LEN_INSN)) u_asm (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (asm_valid_c),
      .byte_i      (byte_i),
      .word_c      (word_c),
      .word_ready_c(word_ready_c)
   );

   always_comb begin
      state_d  = state_q;
      cnt_lo_d = cnt_lo_q;
      n_d      = n_q;
      widx_d   = widx_q;
      we_d     = wr_busy_c;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      n16_c    = {byte_i, cnt_lo_q};
`ifdef INSN_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         LDR_HDR_LO: begin
            if (accept_c) begin
               cnt_lo_d = byte_i;
               state_d  = LDR_HDR_HI;
            end
         end
         LDR_HDR_HI: begin
            if (accept_c) begin
               if (n16_c == '0) begin
                  state_d = LDR_DONE;
               end else if (32'(n16_c) > MAX_WORDS) begin
                  state_d = LDR_ERR;
               end else begin
                  n_d     = IDX_W'(n16_c);
                  state_d = LDR_DATA;
               end
            end
         end
         LDR_DATA: begin
            if (asm_valid_c) begin
`ifdef INSN_LOADER_CHECKSUM_EN
               sum_d = sum_q + byte_i;
`endif
               if (word_ready_c) begin
                  we_d    = 1'b1;
                  waddr_d = widx_q[MEM_INSN_ADDR-1:0];
                  wdata_d = word_c;
                  widx_d  = widx_q + IDX_W'(1);
               end
            end
`ifdef INSN_LOADER_CHECKSUM_EN
            if (asm_valid_c && word_ready_c && (widx_d == n_q)) state_d = LDR_CSUM;
`else
            // Finish only once the last word has actually been taken by the memory.
            if (all_words_c && !wr_busy_c) state_d = LDR_DONE;
`endif
         end
`ifdef INSN_LOADER_CHECKSUM_EN
         LDR_CSUM: begin
            // Accepting here implies any pending write completes this same cycle.
            if (accept_c) state_d = (LEN_BYTE'(sum_q + byte_i) == '0) ? LDR_DONE : LDR_ERR;
         end
`endif
         default: ;
      endcase
      if (state_d == LDR_ERR) we_d = 1'b0;
      core_rst_d = (state_d != LDR_DONE);
      done_d     = (state_d == LDR_DONE);
      err_d      = (state_d == LDR_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LDR_HDR_LO;
         cnt_lo_q   <= '0;
         n_q        <= '0;
         widx_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef INSN_LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_lo_q   <= cnt_lo_d;
         n_q        <= n_d;
         widx_q     <= widx_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         core_rst_q <= core_rst_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef INSN_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   assign we_o       = we_q;
   assign waddr_o    = waddr_q;
   assign wdata_o    = wdata_q;
   assign core_rst_o = core_rst_q;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_insn_loader.sv
// Bench for insn_loader: header table on a 4-word memory, directed timing sequences and random
// streams against a transaction-level model; follows INSN_LOADER_CHECKSUM_EN when defined.
module tb_insn_loader;

   localparam int unsigned SA = 2;

   logic clk = 1'b0;
   logic rst = 1'b1, valid_i = 1'b0, mem_stall_i = 1'b0;
   logic [7:0] byte_i = 8'h00;

   logic stall_o, we_o, core_rst_o, done_o, err_o;
   logic [9:0]  waddr_o;
   logic [31:0] wdata_o;
   logic s_stall_o, s_we_o, s_core_rst_o, s_done_o, s_err_o;
   logic [SA-1:0] s_waddr_o;
   logic [31:0]   s_wdata_o;

   insn_loader dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .byte_i(byte_i), .stall_o(stall_o),
      .mem_stall_i(mem_stall_i), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .core_rst_o(core_rst_o), .done_o(done_o), .err_o(err_o)
   );

   insn_loader #(.MEM_INSN_ADDR(SA)) dut_s (
      .clk(clk), .rst(rst), .valid_i(valid_i), .byte_i(byte_i), .stall_o(s_stall_o),
      .mem_stall_i(mem_stall_i), .we_o(s_we_o), .waddr_o(s_waddr_o), .wdata_o(s_wdata_o),
      .core_rst_o(s_core_rst_o), .done_o(s_done_o), .err_o(s_err_o)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   bit sel = 1'b0;
   logic m_stall, m_we, m_crst, m_done, m_err;
   logic [31:0] m_addr, m_data;

   always_comb begin
      if (sel) begin
         m_stall = s_stall_o; m_we = s_we_o; m_crst = s_core_rst_o; m_done = s_done_o;
         m_err = s_err_o; m_addr = 32'(s_waddr_o); m_data = s_wdata_o;
      end else begin
         m_stall = stall_o; m_we = we_o; m_crst = core_rst_o; m_done = done_o;
         m_err = err_o; m_addr = 32'(waddr_o); m_data = wdata_o;
      end
   end

   logic [7:0]  stim[$];
   logic [31:0] exp_words[$], log_addr[$], log_data[$];
   bit exp_done, exp_err;
   int exp_acc, acc_cnt, term_cyc, cyc, stall_pct, stall_left;
   bit gaps;
   logic tr_we [0:255], tr_stall [0:255], tr_done [0:255], tr_err [0:255], tr_crst [0:255];
   logic [31:0] tr_addr [0:255], tr_data [0:255];

   typedef struct {
      logic [7:0] lo, hi;
      bit         done, err;
      int         nwr, term;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; valid_i = 1'b0; mem_stall_i = 1'b0;
      stall_pct = 0; stall_left = 0; gaps = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One clock: drive inputs after the edge, observe at the falling edge.
   task automatic cycle(input logic v, input logic [7:0] b, output bit acc);
      @(posedge clk); #1;
      valid_i = v; byte_i = b;
      if (stall_left > 0 && m_we) begin
         mem_stall_i = 1'b1; stall_left--;
      end else begin
         mem_stall_i = (int'($urandom_range(99)) < stall_pct);
      end
      @(negedge clk);
      acc = v && !m_stall;
      if (cyc < 256) begin
         tr_we[cyc] = m_we; tr_stall[cyc] = m_stall; tr_done[cyc] = m_done;
         tr_err[cyc] = m_err; tr_crst[cyc] = m_crst; tr_addr[cyc] = m_addr; tr_data[cyc] = m_data;
      end
      if (m_we && !mem_stall_i) begin
         log_addr.push_back(m_addr); log_data.push_back(m_data);
      end
      if ((m_done || m_err) && term_cyc < 0) term_cyc = cyc;
      cyc++;
   endtask

   task automatic run_stream();
      int idx = 0;
      int post = 0;
      bit acc, v;
      logic [7:0] b;
      cyc = 0; term_cyc = -1; acc_cnt = 0;
      log_addr.delete(); log_data.delete();
      while (post < 3) begin
         v = (idx < stim.size()) && (!gaps || $urandom_range(3) != 0);
         b = 8'h00;
         if (v) b = stim[idx];
         cycle(v, b, acc);
         if (acc) begin idx++; acc_cnt++; end
         if (term_cyc >= 0) post++;
         if (cyc > 3000) begin
            errors++; checks++;
            $display("FAIL timeout: no done/err after %0d cycles", cyc);
            break;
         end
      end
   endtask

   // Reference: decode the whole stream as a transaction list.
   task automatic model(input int aw);
      int n;
      logic [7:0]  sum;
      logic [31:0] w;
      exp_words.delete();
      exp_done = 1'b0; exp_err = 1'b0; sum = 8'h00;
      n = int'({stim[1], stim[0]});
      if (n > (1 << aw)) begin
         exp_err = 1'b1; exp_acc = 2;
      end else begin
         for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
               w = w + (32'(stim[2 + 4 * i + k]) << (8 * k));
               sum = sum + stim[2 + 4 * i + k];
            end
            exp_words.push_back(w);
         end
         exp_acc = 2 + 4 * n;
`ifdef INSN_LOADER_CHECKSUM_EN
         if (n != 0) begin
            exp_acc++;
            if (8'(sum + stim[2 + 4 * n]) == 8'h00) exp_done = 1'b1;
            else exp_err = 1'b1;
         end else exp_done = 1'b1;
`else
         exp_done = 1'b1;
`endif
      end
   endtask

   task automatic check_result(input string tag);
      chk({tag, "_nwr"}, 32'(log_addr.size()), 32'(exp_words.size()));
      for (int i = 0; i < log_addr.size() && i < exp_words.size(); i++) begin
         chk({tag, "_addr"}, log_addr[i], 32'(i));
         chk({tag, "_data"}, log_data[i], exp_words[i]);
      end
      chk({tag, "_done"}, 32'(m_done), 32'(exp_done));
      chk({tag, "_err"}, 32'(m_err), 32'(exp_err));
      chk({tag, "_core_rst"}, 32'(m_crst), 32'(!exp_done));
      chk({tag, "_accepted"}, 32'(acc_cnt), 32'(exp_acc));
   endtask

   task automatic push_t1();
      stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef INSN_LOADER_CHECKSUM_EN
      stim.push_back(8'h9C);
`endif
   endtask

   initial begin
      bit acc;
      int n;
      logic [7:0] sum, cs;

      // Reset state while rst is still asserted
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_stall", 32'(stall_o), 0);
      chk("rst_we", 32'(we_o), 0);
      chk("rst_waddr", 32'(waddr_o), 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_core_rst", 32'(core_rst_o), 1);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_err", 32'(err_o), 0);

      // Header table on the 4-word memory: {lo, hi, done, err, writes, terminal cycle}
      tbl[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 0, 2};
      tbl[1] = '{8'h01, 8'h00, 1'b1, 1'b0, 1, 7};
      tbl[2] = '{8'h04, 8'h00, 1'b1, 1'b0, 4, 19};
      tbl[3] = '{8'h05, 8'h00, 1'b0, 1'b1, 0, 2};
      tbl[4] = '{8'h00, 8'h01, 1'b0, 1'b1, 0, 2};
      tbl[5] = '{8'h03, 8'h00, 1'b1, 1'b0, 3, 15};
      sel = 1'b1;
      for (int t = 0; t < 6; t++) begin
         do_reset();
         stim = '{tbl[t].lo, tbl[t].hi};
         sum = 8'h00;
         if (tbl[t].err || tbl[t].nwr == 0) begin
            stim.push_back(8'hA5); stim.push_back(8'h5A);
         end else begin
            for (int j = 0; j < 4 * tbl[t].nwr; j++) begin
               stim.push_back(8'(17 * j + 3)); sum = sum + 8'(17 * j + 3);
            end
`ifdef INSN_LOADER_CHECKSUM_EN
            stim.push_back(8'(0 - sum));
`endif
         end
         run_stream();
         model(SA);
         chk("tbl_done", 32'(m_done), 32'(tbl[t].done));
         chk("tbl_err", 32'(m_err), 32'(tbl[t].err));
         chk("tbl_nwr", 32'(log_addr.size()), 32'(tbl[t].nwr));
         chk("tbl_term", 32'(term_cyc), 32'(tbl[t].term));
         check_result("tbl");
      end
      sel = 1'b0;

      // Two words, no stalls: cycle-exact write and completion timing
      do_reset(); push_t1(); run_stream(); model(10);
      check_result("t1");
      chk("t1_we5", 32'(tr_we[5]), 0);
      chk("t1_we6", 32'(tr_we[6]), 1);
      chk("t1_addr6", tr_addr[6], 0);
      chk("t1_data6", tr_data[6], 32'h44332211);
      chk("t1_we10", 32'(tr_we[10]), 1);
      chk("t1_addr10", tr_addr[10], 1);
      chk("t1_data10", tr_data[10], 32'h88776655);
      chk("t1_done10", 32'(tr_done[10]), 0);
      chk("t1_crst10", 32'(tr_crst[10]), 1);
      chk("t1_done11", 32'(tr_done[11]), 1);
      chk("t1_crst11", 32'(tr_crst[11]), 0);
      chk("t1_stall11", 32'(tr_stall[11]), 1);

      // Empty load: done right after count_hi, later bytes refused
      do_reset(); stim = '{8'h00, 8'h00, 8'h12, 8'h34}; run_stream(); model(10);
      check_result("t2");
      chk("t2_done1", 32'(tr_done[1]), 0);
      chk("t2_done2", 32'(tr_done[2]), 1);
      chk("t2_stall2", 32'(tr_stall[2]), 1);
      chk("t2_stall3", 32'(tr_stall[3]), 1);
      chk("t2_crst2", 32'(tr_crst[2]), 0);

      // Memory stalls the first write for three cycles
      do_reset(); push_t1(); stall_left = 3; run_stream(); model(10);
      check_result("t3");
      for (int c = 6; c <= 9; c++) begin
         chk("t3_we_hold", 32'(tr_we[c]), 1);
         chk("t3_addr_hold", tr_addr[c], 0);
         chk("t3_data_hold", tr_data[c], 32'h44332211);
      end
      for (int c = 6; c <= 8; c++) chk("t3_stall", 32'(tr_stall[c]), 1);
      chk("t3_stall9", 32'(tr_stall[9]), 0);
      chk("t3_we10", 32'(tr_we[10]), 0);
      chk("t3_we13", 32'(tr_we[13]), 1);
      chk("t3_done14", 32'(tr_done[14]), 1);

`ifdef INSN_LOADER_CHECKSUM_EN
      // Wrong checksum byte aborts after the data writes
      do_reset(); push_t1(); stim[10] = 8'h9D; run_stream(); model(10);
      check_result("t5");
      chk("t5_err", 32'(m_err), 1);
      chk("t5_err11", 32'(tr_err[11]), 1);
`endif

      // Reset in the middle of a load, then a full reload from address 0
      do_reset(); push_t1();
      cyc = 0; term_cyc = -1;
      for (int i = 0; i < 7; i++) cycle(1'b1, stim[i], acc);
      do_reset(); run_stream(); model(10);
      check_result("t6");

      // Random streams with gaps and memory back-pressure
      for (int r = 0; r < 30; r++) begin
         do_reset();
         gaps = 1'b1;
         stall_pct = int'($urandom_range(50));
         if ($urandom_range(9) == 0) n = int'($urandom_range(65535, 1025));
         else n = int'($urandom_range(5));
         stim.delete();
         stim.push_back(n[7:0]); stim.push_back(n[15:8]);
         sum = 8'h00;
         if (n <= 1024) begin
            for (int j = 0; j < 4 * n; j++) begin
               cs = 8'($urandom); stim.push_back(cs); sum = sum + cs;
            end
`ifdef INSN_LOADER_CHECKSUM_EN
            if (n != 0) begin
               cs = 8'(0 - sum);
               if ($urandom_range(3) == 0) cs = cs + 8'($urandom_range(255, 1));
               stim.push_back(cs);
            end
`endif
         end
         run_stream();
         model(10);
         check_result("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
